// File: rtl/spike_mem_pkg.sv
// Shared definitions for the spike-tile weight memory path: requester indices,
// arbiter state encoding and default memory geometry.
package spike_mem_pkg;

   localparam int REQ_MAV   = 0;
   localparam int REQ_LEARN = 1;
   localparam int REQ_HOST  = 2;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/spike_rr_pick.sv
// Combinational round-robin pick: first eligible requester at or above ptr,
// wrapping; requesters flagged in excl are skipped.
module spike_rr_pick #(
   parameter int N_REQ = 3,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [N_REQ-1:0] excl,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [N_REQ-1:0] elig;
   logic [IDX_W-1:0] cand;

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return IDX_W'(s);
   endfunction

   assign elig = req & ~excl;

   // Scan farthest-first so the candidate closest to ptr is assigned last and wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = wrap_add(ptr, k);
         if (elig[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spike_weight_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port CSR weight BRAM
// between MAV reads, Hebbian write-back and the host loader.
module spike_weight_arbiter
   import spike_mem_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ-1:0]            we,
   input  logic [N_REQ*ADDR_W-1:0]     addr,
   input  logic [N_REQ*DATA_W-1:0]     wdata,
   output logic [N_REQ-1:0]            gnt,
   output logic [N_REQ-1:0]            rvalid,
   output logic [DATA_W-1:0]           rdata,
   input  logic                        freeze,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy,
   output logic [$clog2(N_REQ)-1:0]    owner,
   output logic [31:0]                 wait_count
);

   localparam int OWN_W = $clog2(N_REQ);
   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [OWN_W-1:0] OWN_IDLE = OWN_W'(REQ_MAV);

   arb_state_t        state, state_nxt;
   logic [OWN_W-1:0]  owner_q, owner_nxt, rr_ptr, rr_ptr_nxt, owner_inc;
   logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
   logic [31:0]       wait_q;
   logic [N_REQ-1:0]  owner_oh, pick_excl;
   logic [OWN_W-1:0]  pick_ptr, pick_idx;
   logic              pick_found, busy_st, beat, others, burst_end;
   logic              req_own, we_own;
   logic [ADDR_W-1:0] addr_own;
   logic [DATA_W-1:0] wdata_own;
   logic              rd_vld_p [RD_LAT];
   logic [OWN_W-1:0]  rd_tag_p [RD_LAT];

   always_comb begin
      owner_oh  = '0;
      req_own   = 1'b0;
      we_own    = 1'b0;
      addr_own  = '0;
      wdata_own = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == OWN_W'(i)) begin
            owner_oh[i] = 1'b1;
            req_own     = req[i];
            we_own      = we[i];
            addr_own    = addr[i*ADDR_W +: ADDR_W];
            wdata_own   = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign busy_st   = (state == ST_BUSY);
   assign beat      = busy_st & req_own & ~freeze;
   assign others    = |(req & ~owner_oh);
   assign burst_end = busy_st & ~freeze & (~req_own | (beat & (beat_cnt == CNT_LAST) & others));
   assign owner_inc = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);

   // From idle the search starts at rr_ptr; at burst end it starts past the owner.
   assign pick_ptr  = busy_st ? owner_inc : rr_ptr;
   assign pick_excl = busy_st ? owner_oh : '0;

   spike_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (OWN_W)
   ) u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .excl  (pick_excl),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner_q;
      rr_ptr_nxt   = rr_ptr;
      beat_cnt_nxt = beat_cnt;
      case (state)
         ST_IDLE: begin
            if (!freeze && pick_found) begin
               state_nxt    = ST_BUSY;
               owner_nxt    = pick_idx;
               beat_cnt_nxt = '0;
            end
         end
         default: begin
            if (beat && beat_cnt != CNT_LAST) beat_cnt_nxt = beat_cnt + CNT_W'(1);
            if (burst_end) begin
               rr_ptr_nxt   = owner_inc;
               beat_cnt_nxt = '0;
               if (pick_found) begin
                  owner_nxt = pick_idx;
               end else begin
                  state_nxt = ST_IDLE;
                  owner_nxt = OWN_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         owner_q  <= OWN_IDLE;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner_q  <= owner_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wait_q <= '0;
      else if (!freeze && (|(req & ~gnt)) && wait_q != '1) wait_q <= wait_q + 32'd1;
   end

   assign gnt       = beat ? owner_oh : '0;
   assign mem_en    = beat;
   assign mem_we    = beat & we_own;
   assign mem_addr  = beat ? addr_own : '0;
   assign mem_wdata = beat ? wdata_own : '0;

   // Read-return stage p0..p(RD_LAT-1): issue tag travels with the BRAM latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < RD_LAT; s++) begin
            rd_vld_p[s] <= 1'b0;
            rd_tag_p[s] <= '0;
         end
      end else begin
         rd_vld_p[0] <= mem_en & ~mem_we;
         rd_tag_p[0] <= owner_q;
         for (int s = 1; s < RD_LAT; s++) begin
            rd_vld_p[s] <= rd_vld_p[s-1];
            rd_tag_p[s] <= rd_tag_p[s-1];
         end
      end
   end

   always_comb begin
      rvalid = '0;
      for (int i = 0; i < N_REQ; i++)
         rvalid[i] = rd_vld_p[RD_LAT-1] & (rd_tag_p[RD_LAT-1] == OWN_W'(i));
   end

   assign rdata      = rd_vld_p[RD_LAT-1] ? mem_rdata : '0;
   assign busy       = busy_st;
   assign owner      = owner_q;
   assign wait_count = wait_q;

endmodule
